// File: rtl/card_draw_arbiter.sv
// card_draw_arbiter: round-robin draw arbiter for a two-hand card game.
// Issues pip strobes to a card source, scores cards and tracks bust state.
module card_draw_arbiter #(
    parameter int LAT       = 1,
    parameter int MAX_CARDS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       pip,
    input  logic [3:0] number,
    output logic       card_valid,
    output logic       card_owner,
    output logic [3:0] card_val,
    output logic [6:0] tot_p,
    output logic [6:0] tot_d,
    output logic [2:0] cnt_p,
    output logic [2:0] cnt_d,
    output logic       bust_p,
    output logic       bust_d,
    output logic       busy,
    output logic       err
);

    // Extra wait cycles between the issue cycle and the sampling cycle.
    localparam logic [1:0] WAITS = 2'(LAT - 1);
    localparam logic [2:0] MAXC  = 3'(MAX_CARDS);
    localparam logic [6:0] LIMIT = 7'd21;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t     state;
    logic [1:0] wcnt;
    logic       ptr;
    logic       owner;

    logic       elig_p;
    logic       elig_d;
    logic       any_elig;
    logic       pick_d;

    logic       dec_ok;
    logic [3:0] dec_val;
    logic [6:0] dec_add;

    logic [6:0] hand_tot;
    logic [2:0] hand_cnt;
    logic [6:0] new_tot;
    logic [2:0] new_cnt;
    logic       new_bust;

    // Eligibility and round-robin pick; ptr=1 favours the dealer.
    always_comb begin
        elig_p   = req[0] & (cnt_p < MAXC) & ~bust_p;
        elig_d   = req[1] & (cnt_d < MAXC) & ~bust_d;
        any_elig = elig_p | elig_d;
        pick_d   = elig_d & (~elig_p | ptr);
    end

    // Map the raw card number to a pip value and a half-point increment.
    always_comb begin
        dec_ok  = 1'b0;
        dec_val = 4'd0;
        dec_add = 7'd0;
        if (number >= 4'd1 && number <= 4'd10) begin
            dec_ok  = 1'b1;
            dec_val = number;
            dec_add = {2'b00, number, 1'b0};
        end else if (number >= 4'd11 && number <= 4'd13) begin
            dec_ok  = 1'b1;
            dec_val = 4'd11;
            dec_add = 7'd1;
        end
    end

    // Next hand state for whichever side owns the draw in flight.
    always_comb begin
        hand_tot = owner ? tot_d : tot_p;
        hand_cnt = owner ? cnt_d : cnt_p;
        new_tot  = hand_tot + dec_add;
        new_cnt  = hand_cnt + 3'd1;
        new_bust = new_tot > LIMIT;
    end

    // Draw FSM with registered strobes, delivery outputs and hand state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wcnt       <= 2'd0;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            gnt        <= 2'b00;
            pip        <= 1'b0;
            card_valid <= 1'b0;
            card_owner <= 1'b0;
            card_val   <= 4'd0;
            tot_p      <= 7'd0;
            tot_d      <= 7'd0;
            cnt_p      <= 3'd0;
            cnt_d      <= 3'd0;
            bust_p     <= 1'b0;
            bust_d     <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            gnt        <= 2'b00;
            pip        <= 1'b0;
            card_valid <= 1'b0;
            err        <= 1'b0;
            if (clear) begin
                state  <= S_IDLE;
                wcnt   <= 2'd0;
                ptr    <= 1'b0;
                busy   <= 1'b0;
                tot_p  <= 7'd0;
                tot_d  <= 7'd0;
                cnt_p  <= 3'd0;
                cnt_d  <= 3'd0;
                bust_p <= 1'b0;
                bust_d <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (any_elig) begin
                            state <= S_ISSUE;
                            gnt   <= pick_d ? 2'b10 : 2'b01;
                            pip   <= 1'b1;
                            busy  <= 1'b1;
                            owner <= pick_d;
                            ptr   <= ~pick_d;
                        end
                    end
                    S_ISSUE: begin
                        wcnt <= WAITS;
                        if (WAITS == 2'd0) begin
                            state <= S_CAPTURE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (wcnt == 2'd1) begin
                            state <= S_CAPTURE;
                        end else begin
                            wcnt <= wcnt - 2'd1;
                        end
                    end
                    S_CAPTURE: begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        card_valid <= 1'b1;
                        card_owner <= owner;
                        if (dec_ok) begin
                            card_val <= dec_val;
                            if (owner) begin
                                tot_d  <= new_tot;
                                cnt_d  <= new_cnt;
                                bust_d <= new_bust;
                            end else begin
                                tot_p  <= new_tot;
                                cnt_p  <= new_cnt;
                                bust_p <= new_bust;
                            end
                        end else begin
                            card_val <= 4'd0;
                            err      <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_card_draw_arbiter.sv
// tb_card_draw_arbiter: directed bench for card_draw_arbiter.
// Two instances (LAT=1 and LAT=3) checked against a card scoreboard.
module tb_card_draw_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       clear_a = 1'b0, clear_b = 1'b0;
    logic [1:0] req_a = 2'b00, req_b = 2'b00;
    logic [3:0] number_a = 4'd15, number_b = 4'd15;

    logic [1:0] gnt_a, gnt_b;
    logic       pip_a, pip_b;
    logic       card_valid_a, card_valid_b;
    logic       card_owner_a, card_owner_b;
    logic [3:0] card_val_a, card_val_b;
    logic [6:0] tot_p_a, tot_d_a, tot_p_b, tot_d_b;
    logic [2:0] cnt_p_a, cnt_d_a, cnt_p_b, cnt_d_b;
    logic       bust_p_a, bust_d_a, bust_p_b, bust_d_b;
    logic       busy_a, busy_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       owner;
        logic [3:0] val;
        logic       e;
        logic [6:0] tot;
        logic [2:0] cnt;
        logic       bust;
    } card_t;

    typedef struct {
        logic [1:0] gnt;
        logic       pip;
        logic       cv;
        logic       owner;
        logic [3:0] val;
        logic [6:0] tot_p;
        logic [6:0] tot_d;
        logic [2:0] cnt_p;
        logic [2:0] cnt_d;
        logic       bust_p;
        logic       bust_d;
        logic       busy;
        logic       err;
    } obs_t;

    card_t sb[$];
    int    m_tot[2][2];
    int    m_cnt[2][2];
    bit    m_bust[2][2];

    card_draw_arbiter #(.LAT(1), .MAX_CARDS(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a), .req(req_a),
        .gnt(gnt_a), .pip(pip_a), .number(number_a),
        .card_valid(card_valid_a), .card_owner(card_owner_a),
        .card_val(card_val_a), .tot_p(tot_p_a), .tot_d(tot_d_a),
        .cnt_p(cnt_p_a), .cnt_d(cnt_d_a), .bust_p(bust_p_a),
        .bust_d(bust_d_a), .busy(busy_a), .err(err_a)
    );

    card_draw_arbiter #(.LAT(3), .MAX_CARDS(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b), .req(req_b),
        .gnt(gnt_b), .pip(pip_b), .number(number_b),
        .card_valid(card_valid_b), .card_owner(card_owner_b),
        .card_val(card_val_b), .tot_p(tot_p_b), .tot_d(tot_d_b),
        .cnt_p(cnt_p_b), .cnt_d(cnt_d_b), .bust_p(bust_p_b),
        .bust_d(bust_d_b), .busy(busy_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int d, output obs_t o);
        if (d == 0) begin
            o.gnt = gnt_a; o.pip = pip_a; o.cv = card_valid_a;
            o.owner = card_owner_a; o.val = card_val_a;
            o.tot_p = tot_p_a; o.tot_d = tot_d_a;
            o.cnt_p = cnt_p_a; o.cnt_d = cnt_d_a;
            o.bust_p = bust_p_a; o.bust_d = bust_d_a;
            o.busy = busy_a; o.err = err_a;
        end else begin
            o.gnt = gnt_b; o.pip = pip_b; o.cv = card_valid_b;
            o.owner = card_owner_b; o.val = card_val_b;
            o.tot_p = tot_p_b; o.tot_d = tot_d_b;
            o.cnt_p = cnt_p_b; o.cnt_d = cnt_d_b;
            o.bust_p = bust_p_b; o.bust_d = bust_d_b;
            o.busy = busy_b; o.err = err_b;
        end
    endtask

    task automatic set_req(input int d, input logic [1:0] r);
        if (d == 0) req_a = r; else req_b = r;
    endtask

    task automatic set_num(input int d, input logic [3:0] n);
        if (d == 0) number_a = n; else number_b = n;
    endtask

    task automatic set_clear(input int d, input logic c);
        if (d == 0) clear_a = c; else clear_b = c;
    endtask

    task automatic model_clear(input int d);
        for (int s = 0; s < 2; s++) begin
            m_tot[d][s] = 0;
            m_cnt[d][s] = 0;
            m_bust[d][s] = 1'b0;
        end
    endtask

    task automatic model(input int d, input int side, input logic [3:0] num,
                         output card_t e);
        e.owner = side[0];
        e.val   = 4'd0;
        e.e     = 1'b0;
        if (num >= 4'd1 && num <= 4'd10) begin
            e.val = num;
            m_tot[d][side] += 2 * int'(num);
            m_cnt[d][side] += 1;
        end else if (num >= 4'd11 && num <= 4'd13) begin
            e.val = 4'd11;
            m_tot[d][side] += 1;
            m_cnt[d][side] += 1;
        end else begin
            e.e = 1'b1;
        end
        if (m_tot[d][side] > 21) m_bust[d][side] = 1'b1;
        e.tot  = 7'(m_tot[d][side]);
        e.cnt  = 3'(m_cnt[d][side]);
        e.bust = m_bust[d][side];
    endtask

    // One draw: request, expect a grant to side, feed num exactly LAT later.
    task automatic draw(input int d, input logic [1:0] r, input int side,
                        input logic [3:0] num, input bit hold);
        obs_t  o;
        card_t e;
        int    lat;
        lat = (d == 0) ? 1 : 3;
        set_req(d, r);
        @(posedge clk); #1;
        sample(d, o);
        check("gnt", o.gnt, (side == 0) ? 2'b01 : 2'b10);
        check("pip", o.pip, 1'b1);
        check("busy_draw", o.busy, 1'b1);
        if (!hold) set_req(d, 2'b00);
        model(d, side, num, e);
        sb.push_back(e);
        repeat (lat) @(posedge clk);
        #1 set_num(d, num);
        @(posedge clk); #1;
        set_num(d, 4'd15);
        sample(d, o);
        e = sb.pop_front();
        check("card_valid", o.cv, 1'b1);
        check("card_owner", o.owner, e.owner);
        check("card_val", o.val, e.val);
        check("err", o.err, e.e);
        check("busy_done", o.busy, 1'b0);
        check("tot", e.owner ? o.tot_d : o.tot_p, e.tot);
        check("cnt", e.owner ? o.cnt_d : o.cnt_p, e.cnt);
        check("bust", e.owner ? o.bust_d : o.bust_p, e.bust);
    endtask

    task automatic no_grant(input int d, input logic [1:0] r);
        obs_t o;
        set_req(d, r);
        repeat (3) begin
            @(posedge clk); #1;
            sample(d, o);
            check("no_gnt", o.gnt, 2'b00);
            check("no_busy", o.busy, 1'b0);
        end
        set_req(d, 2'b00);
    endtask

    task automatic do_clear(input int d);
        obs_t o;
        set_clear(d, 1'b1);
        @(posedge clk); #1;
        set_clear(d, 1'b0);
        model_clear(d);
        sample(d, o);
        check("clr_tot", {o.tot_p, o.tot_d}, 14'd0);
        check("clr_cnt", {o.cnt_p, o.cnt_d}, 6'd0);
        check("clr_bust", {o.bust_p, o.bust_d}, 2'b00);
        check("clr_busy", o.busy, 1'b0);
    endtask

    initial begin
        obs_t o;
        model_clear(0);
        model_clear(1);

        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            sample(d, o);
            check("rst_gnt", o.gnt, 2'b00);
            check("rst_pip", o.pip, 1'b0);
            check("rst_cv", o.cv, 1'b0);
            check("rst_owner", o.owner, 1'b0);
            check("rst_val", o.val, 4'd0);
            check("rst_tot", {o.tot_p, o.tot_d}, 14'd0);
            check("rst_cnt", {o.cnt_p, o.cnt_d}, 6'd0);
            check("rst_bust", {o.bust_p, o.bust_d}, 2'b00);
            check("rst_busy", o.busy, 1'b0);
            check("rst_err", o.err, 1'b0);
        end
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic player draw, LAT=1.
        draw(0, 2'b01, 0, 4'd7, 1'b0);

        // Round robin with both requests held.
        do_clear(0);
        draw(0, 2'b11, 0, 4'd3, 1'b1);
        draw(0, 2'b11, 1, 4'd12, 1'b1);
        draw(0, 2'b11, 0, 4'd5, 1'b1);
        set_req(0, 2'b00);

        // Player busts, then is ignored; lone eligible dealer still granted.
        do_clear(0);
        draw(0, 2'b01, 0, 4'd6, 1'b0);
        draw(0, 2'b01, 0, 4'd5, 1'b0);
        no_grant(0, 2'b01);
        draw(0, 2'b10, 1, 4'd10, 1'b0);
        draw(0, 2'b11, 1, 4'd2, 1'b0);
        no_grant(0, 2'b11);

        // Dealer fills the hand with pictures.
        do_clear(0);
        draw(0, 2'b10, 1, 4'd11, 1'b0);
        draw(0, 2'b10, 1, 4'd12, 1'b0);
        draw(0, 2'b10, 1, 4'd13, 1'b0);
        draw(0, 2'b10, 1, 4'd11, 1'b0);
        draw(0, 2'b10, 1, 4'd12, 1'b0);
        no_grant(0, 2'b10);
        draw(0, 2'b11, 0, 4'd1, 1'b0);

        // Clear and request together: clear wins.
        set_req(0, 2'b01);
        set_clear(0, 1'b1);
        @(posedge clk); #1;
        sample(0, o);
        check("clr_req_gnt", o.gnt, 2'b00);
        check("clr_req_busy", o.busy, 1'b0);
        check("clr_req_tot", o.tot_p, 7'd0);
        set_clear(0, 1'b0);
        set_req(0, 2'b00);
        model_clear(0);
        draw(0, 2'b01, 0, 4'd14, 1'b0);
        draw(0, 2'b01, 0, 4'd4, 1'b0);

        // LAT=3 instance.
        draw(1, 2'b01, 0, 4'd9, 1'b0);
        set_req(1, 2'b01);
        @(posedge clk); #1;
        sample(1, o);
        check("w_gnt", o.gnt, 2'b01);
        set_req(1, 2'b00);
        @(posedge clk); #1;
        sample(1, o);
        check("w_busy", o.busy, 1'b1);
        set_clear(1, 1'b1);
        set_num(1, 4'd5);
        @(posedge clk); #1;
        set_clear(1, 1'b0);
        model_clear(1);
        sample(1, o);
        check("w_idle", o.busy, 1'b0);
        check("w_tot", o.tot_p, 7'd0);
        check("w_cnt", o.cnt_p, 3'd0);
        check("w_cv", o.cv, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
            sample(1, o);
            check("w_no_cv", o.cv, 1'b0);
        end
        set_num(1, 4'd15);
        draw(1, 2'b10, 1, 4'd0, 1'b0);
        draw(1, 2'b10, 1, 4'd13, 1'b0);

        // Asynchronous reset while instance b is in ISSUE.
        set_req(1, 2'b01);
        @(posedge clk); #1;
        sample(1, o);
        check("r_pip", o.pip, 1'b1);
        set_req(1, 2'b00);
        #1 rst_n = 1'b0;
        #1;
        sample(1, o);
        check("r_gnt", o.gnt, 2'b00);
        check("r_pip0", o.pip, 1'b0);
        check("r_busy", o.busy, 1'b0);
        check("r_tot_d", o.tot_d, 7'd0);
        check("r_cnt_d", o.cnt_d, 3'd0);
        sample(0, o);
        check("r_a_tot", o.tot_p, 7'd0);
        check("r_a_cnt", o.cnt_p, 3'd0);
        model_clear(0);
        model_clear(1);
        set_num(1, 4'd7);
        #3 rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            sample(1, o);
            check("r_no_cv", o.cv, 1'b0);
            check("r_idle", o.busy, 1'b0);
        end
        set_num(1, 4'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
